// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: registered-PC instruction fetch stage with a prefetch queue.
//   Issues one-at-a-time requests to instruction memory, buffers returned words
//   together with their PC in a DEPTH-entry queue, and presents the queue head
//   to decode through a valid/ready handshake. A redirect flushes the queue and
//   restarts fetch at the new (word-aligned) PC.
// Parameters: DEPTH (queue entries, power of two, >= 2), RESET_PC.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   imem_req_o, imem_addr_o       fetch request pulse and word address
//   imem_rvalid_i, imem_rdata_i   fetch response
//   redirect_i, redirect_pc_i     flush and restart at a new PC
//   instr_valid_o, instr_ready_i  head handshake toward decode
//   instr_o, pc_o, pc_plus4_o     head instruction, its PC and PC+4
// Optional: define IFU_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o, saturating
//   counters of starved-consumer cycles and redirect cycles.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  // pc_plus4 is stored rather than derived so the whole head reads 0 out of reset
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        queue_q [DEPTH];

  logic          req_c;
  logic          push_c;
  logic          pop_c;

  // Control state, fetch PC, occupancy and pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Next-state, request issue and queue bookkeeping
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    req_c      = 1'b0;
    push_c     = 1'b0;
    pop_c      = (count_q != '0) && instr_ready_i;

    if (redirect_i) begin
      // Flush wins over push/pop; an in-flight response becomes stale
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      unique case (state_q)
        S_WAIT:    state_d = imem_rvalid_i ? S_FETCH : S_DISCARD;
        S_DISCARD: state_d = imem_rvalid_i ? S_FETCH : S_DISCARD;
        default:   state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          // Space is reserved at issue, so a response always has a slot
          if (count_q < CW'(DEPTH)) begin
            req_c   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            push_c     = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid_i) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Queue storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) queue_q[i] <= '0;
    end else if (push_c) begin
      queue_q[wr_ptr_q] <= '{pc: fetch_pc_q, pc_plus4: fetch_pc_q + 32'd4, instr: imem_rdata_i};
    end
  end

  // Request is held low while reset is asserted
  assign imem_req_o    = req_c && !rst_i;
  assign imem_addr_o   = fetch_pc_q;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = queue_q[rd_ptr_q].instr;
  assign pc_o          = queue_q[rd_ptr_q].pc;
  assign pc_plus4_o    = queue_q[rd_ptr_q].pc_plus4;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counters of starved-consumer cycles and redirect cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!instr_valid_o && instr_ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_i && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
